// File: rtl/dropout_pkg.sv
// Shared constants and helpers for the dropout unit: LFSR geometry, per-lane seed derivation
// and the Galois LFSR step function.
package dropout_pkg;

  localparam int          LFSR_W      = 16;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] SEED_STRIDE = 16'h9E37;

  // Lanes are spread over the sequence by a fixed stride; zero would lock the LFSR up.
  function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] base,
                                                  input int unsigned       lane);
    logic [31:0]       mult;
    logic [LFSR_W-1:0] s;
    mult = lane * {16'd0, SEED_STRIDE};
    s    = base + mult[LFSR_W-1:0];
    if (s == '0) s = 16'h0001;
    return s;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/dropout_lfsr.sv
// One 16-bit Galois LFSR lane: reset or load returns it to its seed, step advances one position.
module dropout_lfsr
  import dropout_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;

  // Reload wins over advance so a seed_load always lands on the seed itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= seed;
    end else if (load) begin
      value_q <= seed;
    end else if (step) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/dropout_unit.sv
// Per-lane random dropout with a one-beat output register and a saturating drop counter.
// Optional keep-lane Q8.8 scaling is built only when DROPOUT_SCALE_EN is defined.
module dropout_unit
  import dropout_pkg::*;
#(
  parameter int          LANES = 8,
  parameter int          DW    = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [15:0]           thresh,
  input  logic [15:0]           scale,
  input  logic                  seed_load,
  input  logic                  stat_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic [LANES-1:0]      mask_out,
  output logic [31:0]           drop_count
);

  logic                  accept;
  logic                  lfsr_step;
  logic [LFSR_W-1:0]     lfsr_val [LANES];

  logic                  ov_q, ov_d;
  logic [LANES*DW-1:0]   od_q, od_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [LANES-1:0]      keep_c;
  logic [31:0]           drops_c;

  assign in_ready  = !ov_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign lfsr_step = accept && enable;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [LFSR_W-1:0] LANE_SEED = lane_seed(SEED, i);
    dropout_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (seed_load),
      .step  (lfsr_step),
      .seed  (LANE_SEED),
      .value (lfsr_val[i])
    );
  end

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

`ifdef DROPOUT_SCALE_EN
  localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+16:0] v);
    logic signed [DW+16:0] hi, lo;
    hi = {{17{1'b0}}, DMAX};
    lo = {{17{1'b1}}, DMIN};
    if (v > hi)      return DMAX;
    else if (v < lo) return DMIN;
    else             return v[DW-1:0];
  endfunction

  // Product is widened by one bit so the unsigned scale can enter as a positive signed operand.
  function automatic logic signed [DW-1:0] scale_lane(input logic signed [DW-1:0] x,
                                                      input logic [15:0]          s);
    logic signed [DW+16:0] xe, se, prod;
    xe   = {{17{x[DW-1]}}, x};
    se   = {{(DW+1){1'b0}}, s};
    prod = xe * se;
    return sat_dw(prod >>> 8);
  endfunction
`else
  logic scale_unused;
  assign scale_unused = ^scale;
`endif

  always_comb begin
    ov_d    = ov_q;
    od_d    = od_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    keep_c  = '1;
    drops_c = '0;
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        keep_c[i] = !enable || (lfsr_val[i] >= thresh);
`ifdef DROPOUT_SCALE_EN
        od_d[i*DW +: DW] = keep_c[i] ? scale_lane(in_data[i*DW +: DW], scale) : '0;
`else
        od_d[i*DW +: DW] = keep_c[i] ? in_data[i*DW +: DW] : '0;
`endif
        drops_c = drops_c + {31'd0, ~keep_c[i]};
      end
      mask_d = keep_c;
      ov_d   = 1'b1;
      cnt_d  = sat_add32(cnt_q, drops_c);
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
    if (stat_clr) cnt_d = '0;
  end

  // Output register stage: one beat of latency, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_q   <= 1'b0;
      od_q   <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      ov_q   <= ov_d;
      od_q   <= od_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_data   = od_q;
  assign mask_out   = mask_q;
  assign drop_count = cnt_q;

endmodule

// File: tb/tb_dropout_unit.sv
// Self-checking bench for dropout_unit (LANES=4, DW=8) against a behavioural reference model.
module tb_dropout_unit;

  localparam int LANES = 4;
  localparam int DW    = 8;

  logic                 clk = 1'b0;
  logic                 reset, enable, seed_load, stat_clr, in_valid, out_ready;
  logic                 in_ready, out_valid;
  logic [15:0]          thresh, scale;
  logic [LANES*DW-1:0]  in_data, out_data;
  logic [LANES-1:0]     mask_out;
  logic [31:0]          drop_count;

  int total = 0;
  int bad   = 0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  dropout_unit #(.LANES(LANES), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .thresh     (thresh),
    .scale      (scale),
    .seed_load  (seed_load),
    .stat_clr   (stat_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .mask_out   (mask_out),
    .drop_count (drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec rules in plain integer arithmetic.
  int              m_lfsr [LANES];
  bit              m_ov;
  logic [31:0]     m_od;
  logic [3:0]      m_mask;
  longint          m_cnt;

  function automatic int seed_of(input int i);
    int s;
    s = ('hACE1 + i * 'h9E37) % 65536;
    if (s == 0) s = 1;
    return s;
  endfunction

  function automatic int lfsr_adv(input int v);
    return (v % 2 == 1) ? ((v / 2) ^ 'hB400) : (v / 2);
  endfunction

  function automatic int lane_result(input int x, input int s);
`ifdef DROPOUT_SCALE_EN
    int p;
    p = (x * s) >>> 8;
    if (p > 127)  p = 127;
    if (p < -128) p = -128;
    return p;
`else
    return x + 0 * s;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit                  acc;
    int                  drops, x, r;
    logic [31:0]         nd;
    logic [3:0]          nm;
    if (reset) begin
      m_ov   <= 1'b0;
      m_od   <= '0;
      m_mask <= '0;
      m_cnt  <= 0;
      for (int i = 0; i < LANES; i++) m_lfsr[i] <= seed_of(i);
    end else begin
      acc   = in_valid && (!m_ov || out_ready);
      drops = 0;
      nd    = m_od;
      nm    = m_mask;
      if (acc) begin
        for (int i = 0; i < LANES; i++) begin
          nm[i] = !enable || (m_lfsr[i] >= int'(thresh));
          x     = $signed(in_data[i*DW +: DW]);
          r     = nm[i] ? lane_result(x, int'(scale)) : 0;
          nd[i*DW +: DW] = r[7:0];
          if (!nm[i]) drops++;
        end
        m_ov <= 1'b1;
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
      m_od   <= nd;
      m_mask <= nm;
      if (stat_clr) m_cnt <= 0;
      else if (acc) m_cnt <= (m_cnt + drops > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + drops;
      for (int i = 0; i < LANES; i++) begin
        if (seed_load)          m_lfsr[i] <= seed_of(i);
        else if (acc && enable) m_lfsr[i] <= lfsr_adv(m_lfsr[i]);
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", {63'd0, in_ready}, {63'd0, (!m_ov || out_ready)});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    if (m_ov) begin
      check("out_data", {32'd0, out_data}, {32'd0, m_od});
      check("mask_out", {60'd0, mask_out}, {60'd0, m_mask});
    end
    check("drop_count", {32'd0, drop_count}, m_cnt);
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic en, input logic [15:0] th,
                      input logic sl = 1'b0);
    logic rdy;
    int   n;
    in_valid  = 1'b1;
    in_data   = d;
    enable    = en;
    thresh    = th;
    seed_load = sl;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("accept_timeout", {63'd0, rdy}, 64'd1);
    in_valid  = 1'b0;
    seed_load = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_scale;
    reset = 1'b1; enable = 1'b0; seed_load = 1'b0; stat_clr = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; thresh = '0; scale = 16'h0100; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_mask", {60'd0, mask_out}, 64'd0);
    check("rst_drop_count", {32'd0, drop_count}, 64'd0);
    reset = 1'b0;
    tick();

    // Pass-through with enable low.
    send(32'h2C21160B, 1'b0, 16'hFFFF);
    check("bypass_data", {32'd0, out_data}, 64'h2C21160B);
    check("bypass_mask", {60'd0, mask_out}, 64'hF);
    check("bypass_count", {32'd0, drop_count}, 64'd0);

    // Seeds ACE1/4B18/E94F/8786, then one step E270/258C/C0A7/43C3.
    send(32'h2C21160B, 1'b1, 16'hACE2);
    check("seed_mask", {60'd0, mask_out}, 64'h4);
    check("seed_data", {32'd0, out_data}, 64'h00210000);
    check("seed_count", {32'd0, drop_count}, 64'd3);
    send(32'h2C21160B, 1'b1, 16'hC0A7);
    check("step_mask", {60'd0, mask_out}, 64'h5);
    check("step_data", {32'd0, out_data}, 64'h0021000B);
    check("step_count", {32'd0, drop_count}, 64'd5);

    for (int i = 0; i < 100; i++) send($urandom, 1'b1, 16'h0000);
    check("thresh0_count", {32'd0, drop_count}, 64'd5);

    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_clr", {32'd0, drop_count}, 64'd0);

    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send($urandom, 1'b1, 16'h8000);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    tick();
    tick();

    // Backpressure: held beat must stay put, new beat waits.
    out_ready = 1'b0;
    send(32'h5A3C7E01, 1'b1, 16'h0000);
    in_valid = 1'b1; in_data = 32'h11223344; enable = 1'b1; thresh = 16'h8000;
    repeat (5) begin
      @(negedge clk);
      check("stall_data", {32'd0, out_data}, 64'h5A3C7E01);
      check("stall_ready", {63'd0, in_ready}, 64'd0);
      check("stall_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();

    // Reload alongside an accepted beat, then seed values drive the next decision.
    send(32'h01020304, 1'b1, 16'h8000, 1'b1);
    send(32'h2C21160B, 1'b1, 16'hACE2);
    check("reload_mask", {60'd0, mask_out}, 64'h4);
    tick();

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    send(32'h7F7F7F7F, 1'b1, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_valid", {63'd0, out_valid}, 64'd0);
    check("midreset_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(32'h2C21160B, 1'b1, 16'hACE2);
    check("postreset_mask", {60'd0, mask_out}, 64'h4);
    check("postreset_count", {32'd0, drop_count}, 64'd3);

    // Lanes 80, -100, 10, -1 with scale x2.
    scale = 16'h0200;
    send(32'hFF0A9C50, 1'b1, 16'h0000);
`ifdef DROPOUT_SCALE_EN
    exp_scale = 32'hFE14807F;
`else
    exp_scale = 32'hFF0A9C50;
`endif
    check("scale_data", {32'd0, out_data}, {32'd0, exp_scale});
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
